// File: rtl/spi_slave.sv
// SPI mode-0 responder oversampled on clk; pin-to-action latency SYNC_STAGES+1 clk. tx_ready drops while the one-word buffer is full.
// Optional SPI_SLAVE_OVERRUN_EN: rx_valid holds until rx_ack and words arriving while it is held raise rx_overrun.
module spi_slave #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DEFAULT_TX  = 8'hFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {WAIT_CS, IDLE, LOAD, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_q, cs_q;
  logic [WIDTH-1:0]       tx_buf, tx_shift, rx_shift;
  logic [CW-1:0]          bitcnt;
  logic                   word_done;

  logic             sclk_s, cs_s, mosi_s;
  logic             sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic             tx_wr, load_now, word_end;
  logic [WIDTH-1:0] rx_word, load_word;
  logic             shift_msb_unused;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  assign tx_wr     = tx_valid && tx_ready;
  assign load_word = tx_ready ? DEFAULT_TX : tx_buf;
  assign rx_word   = {rx_shift[WIDTH-2:0], mosi_s};
  // The fall after a completed word reloads rather than shifts, so back-to-back words need no LOAD state.
  assign load_now  = !cs_rise && ((state == LOAD) || (state == SHIFT && sclk_fall && word_done));
  assign word_end  = !cs_rise && (state == SHIFT) && sclk_rise && (bitcnt == CW'(WIDTH - 1));
  assign shift_msb_unused = tx_shift[WIDTH-1];

  // cs synchroniser resets low so WAIT_CS only leaves on a genuinely deselected bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT_CS;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      tx_ready   <= 1'b1;
      tx_buf     <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      bitcnt     <= '0;
      word_done  <= 1'b0;
    end else begin
      // A load in the same clk as a write sees the old (empty) buffer; the new word waits.
      if (tx_wr) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (load_now) begin
        tx_ready <= 1'b1;
      end

      if (load_now) begin
        tx_shift  <= load_word;
        miso      <= load_word[WIDTH-1];
        miso_oe   <= 1'b1;
        bitcnt    <= '0;
        word_done <= 1'b0;
      end

      if (cs_rise) begin
        state     <= IDLE;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
        bitcnt    <= '0;
        word_done <= 1'b0;
      end else begin
        case (state)
          WAIT_CS: if (cs_s) state <= IDLE;
          IDLE:    if (cs_fall) state <= LOAD;
          LOAD:    state <= SHIFT;
          SHIFT: begin
            if (sclk_rise) begin
              rx_shift <= rx_word;
              if (word_end) begin
                bitcnt    <= '0;
                word_done <= 1'b1;
              end else begin
                bitcnt <= bitcnt + CW'(1);
              end
            end else if (sclk_fall && !word_done) begin
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
              miso     <= tx_shift[WIDTH-2];
            end
          end
          default: state <= WAIT_CS;
        endcase
      end

`ifdef SPI_SLAVE_OVERRUN_EN
      if (rx_ack) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (word_end) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
`else
      rx_valid   <= word_end;
      rx_overrun <= 1'b0;
      if (word_end) rx_data <= rx_word;
`endif
    end
  end

`ifndef SPI_SLAVE_OVERRUN_EN
  logic ack_unused;
  assign ack_unused = rx_ack;
`endif

endmodule
